// File: rtl/cmos_capture_win_if.sv
// DVP sensor pins plus the captured pixel stream, bundled as one bus.
// The master side is the sensor/environment and the slave side is the
// capture block.
//
// Handshake: there is no backpressure. pix_valid is a one-cycle strobe.
// pix_data, pix_sof and pix_eol are meaningful only while pix_valid is high.
// frame_done is an independent one-cycle pulse. frame_cnt is a level that
// holds the running output-frame count.
interface cmos_capture_win_if #(
  parameter int DATA_W  = 8,
  parameter int MAX_BPP = 3
);
  logic                      cmos_href;
  logic                      cmos_vsync;
  logic [DATA_W-1:0]         cmos_d;
  logic [DATA_W*MAX_BPP-1:0] pix_data;
  logic                      pix_valid;
  logic                      pix_sof;
  logic                      pix_eol;
  logic                      frame_done;
  logic [15:0]               frame_cnt;

  modport master (
    output cmos_href, cmos_vsync, cmos_d,
    input  pix_data, pix_valid, pix_sof, pix_eol, frame_done, frame_cnt
  );

  modport slave (
    input  cmos_href, cmos_vsync, cmos_d,
    output pix_data, pix_valid, pix_sof, pix_eol, frame_done, frame_cnt
  );
endinterface

// File: rtl/cmos_capture_win.sv
// Camera capture path in the sensor pixel-clock domain. It assembles 1, 2 or
// 3 bytes per pixel, applies a crop window, decimates frames, skips start-up
// frames, and tags frame and line boundaries. MAX_BPP must be at least 2.
module cmos_capture_win #(
  parameter int DATA_W      = 8,
  parameter int MAX_BPP     = 3,
  parameter int CNT_W       = 12,
  parameter int SKIP_FRAMES = 10,
  parameter int VSYNC_POL   = 1
) (
  input  logic             i_cmos_pclk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_x_start,
  input  logic [CNT_W-1:0] i_x_end,
  input  logic [CNT_W-1:0] i_y_start,
  input  logic [CNT_W-1:0] i_y_end,
  input  logic [3:0]       i_decim,
  cmos_capture_win_if.slave bus,
  output logic [2:0]       o_state
);
  localparam int PW  = DATA_W * MAX_BPP;
  localparam int SKW = (SKIP_FRAMES < 1) ? 1 : $clog2(SKIP_FRAMES + 1);
  localparam logic [SKW-1:0] SKIP_N = SKW'(SKIP_FRAMES);
  localparam logic [1:0]     MAXB   = 2'(MAX_BPP);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SKIP   = 3'd1,
    S_WAIT   = 3'd2,
    S_ACTIVE = 3'd3,
    S_DROP   = 3'd4
  } state_t;

  state_t             r_state;
  logic               r_vs, r_vs_d, r_href_d;
  logic [PW-DATA_W-1:0] r_sh;
  logic [SKW-1:0]     r_skip;
  logic [3:0]         r_dec;
  logic [1:0]         r_mode;
  logic [CNT_W-1:0]   r_xs, r_xe, r_ys, r_ye;
  logic [CNT_W-1:0]   r_x, r_y;
  logic [1:0]         r_bc;
  logic               r_line_px, r_sof_pend;
  logic               r_pix_valid, r_pix_sof, r_pix_eol, r_frame_done;
  logic [PW-1:0]      r_pix_data;
  logic [15:0]        r_frame_cnt;

  logic               w_blank, w_blank_d, w_fs, w_fe, w_rise, w_fall;
  logic [1:0]         w_bpp, w_bc;
  logic [CNT_W-1:0]   w_x, w_x_inc, w_y_inc;
  logic               w_last, w_in_win;
  logic [PW-1:0]      w_raw, w_mask, w_pix;
  logic [SKW-1:0]     w_skip_inc;

  // Frame/line edge detection on registered vsync and raw href, plus pixel assembly helpers.
  always_comb begin
    w_blank   = (VSYNC_POL != 0) ? r_vs   : ~r_vs;
    w_blank_d = (VSYNC_POL != 0) ? r_vs_d : ~r_vs_d;
    w_fs      = w_blank_d & ~w_blank;
    w_fe      = ~w_blank_d & w_blank;
    w_rise    = bus.cmos_href & ~r_href_d;
    w_fall    = ~bus.cmos_href & r_href_d;
    case (r_mode)
      2'd0:    w_bpp = 2'd1;
      2'd2:    w_bpp = 2'd3;
      default: w_bpp = 2'd2;
    endcase
    if (w_bpp > MAXB) w_bpp = MAXB;
    // A rising href starts a new line even if the previous one left state behind.
    w_bc     = w_rise ? 2'd0 : r_bc;
    w_x      = w_rise ? '0 : r_x;
    w_x_inc  = (&w_x) ? w_x : w_x + 1'b1;
    w_y_inc  = (&r_y) ? r_y : r_y + 1'b1;
    w_last   = bus.cmos_href && (w_bc == w_bpp - 2'd1);
    w_in_win = (w_x >= r_xs) && (w_x <= r_xe) && (r_y >= r_ys) && (r_y <= r_ye);
    w_raw    = {r_sh, bus.cmos_d};
    w_mask   = '0;
    for (int b = 0; b < MAX_BPP; b++) begin
      if (b < int'(w_bpp)) w_mask[b*DATA_W +: DATA_W] = '1;
    end
    w_pix      = w_raw & w_mask;
    w_skip_inc = r_skip + 1'b1;
  end

  // Capture FSM with registered pixel and frame outputs.
  always_ff @(posedge i_cmos_pclk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_vs         <= 1'b0;
      r_vs_d       <= 1'b0;
      r_href_d     <= 1'b0;
      r_sh         <= '0;
      r_skip       <= '0;
      r_dec        <= '0;
      r_mode       <= '0;
      r_xs         <= '0;
      r_xe         <= '0;
      r_ys         <= '0;
      r_ye         <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_bc         <= '0;
      r_line_px    <= 1'b0;
      r_sof_pend   <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_pix_sof    <= 1'b0;
      r_pix_eol    <= 1'b0;
      r_pix_data   <= '0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_vs         <= bus.cmos_vsync;
      r_vs_d       <= r_vs;
      r_href_d     <= bus.cmos_href;
      r_sh         <= w_raw[PW-DATA_W-1:0];
      r_pix_valid  <= 1'b0;
      r_pix_sof    <= 1'b0;
      r_pix_eol    <= 1'b0;
      r_pix_data   <= '0;
      r_frame_done <= 1'b0;
      // Run-time configuration only takes effect at a frame boundary.
      if (w_fs) begin
        r_mode <= i_mode;
        r_xs   <= i_x_start;
        r_xe   <= i_x_end;
        r_ys   <= i_y_start;
        r_ye   <= i_y_end;
      end
      if (!i_enable) begin
        r_state   <= S_IDLE;
        r_x       <= '0;
        r_y       <= '0;
        r_bc      <= '0;
        r_line_px <= 1'b0;
      end else begin
        if (r_state != S_ACTIVE) begin
          r_x       <= '0;
          r_y       <= '0;
          r_bc      <= '0;
          r_line_px <= 1'b0;
        end
        case (r_state)
          S_IDLE: r_state <= (r_skip < SKIP_N) ? S_SKIP : S_WAIT;
          S_SKIP: begin
            if (w_fe) begin
              r_skip <= w_skip_inc;
              if (w_skip_inc >= SKIP_N) r_state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (w_fs) begin
              r_state    <= (r_dec == 4'd0) ? S_ACTIVE : S_DROP;
              r_dec      <= (r_dec >= i_decim) ? 4'd0 : r_dec + 4'd1;
              r_sof_pend <= 1'b1;
            end
          end
          S_ACTIVE: begin
            if (w_fe) begin
              // End of frame overrides any pixel that completes on the same edge.
              r_frame_done <= 1'b1;
              r_frame_cnt  <= r_frame_cnt + 16'd1;
              r_state      <= S_WAIT;
              r_x          <= '0;
              r_y          <= '0;
              r_bc         <= '0;
              r_line_px    <= 1'b0;
            end else if (bus.cmos_href) begin
              if (w_last) begin
                r_bc      <= 2'd0;
                r_x       <= w_x_inc;
                r_line_px <= 1'b1;
                if (w_in_win) begin
                  r_pix_valid <= 1'b1;
                  r_pix_data  <= w_pix;
                  r_pix_sof   <= r_sof_pend;
                  r_pix_eol   <= (w_x == r_xe);
                  r_sof_pend  <= 1'b0;
                end
              end else begin
                r_bc <= w_bc + 2'd1;
                r_x  <= w_x;
                if (w_rise) r_line_px <= 1'b0;
              end
            end else begin
              // A partial pixel at the end of a line is discarded.
              r_bc <= 2'd0;
              if (w_fall && r_line_px) r_y <= w_y_inc;
            end
          end
          S_DROP: if (w_fe) r_state <= S_WAIT;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.pix_data   = r_pix_data;
  assign bus.pix_valid  = r_pix_valid;
  assign bus.pix_sof    = r_pix_sof;
  assign bus.pix_eol    = r_pix_eol;
  assign bus.frame_done = r_frame_done;
  assign bus.frame_cnt  = r_frame_cnt;
  assign o_state        = r_state;
endmodule
